mul_sequencer: RTL
==================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001: The block SHALL have exactly one clock and one reset, and the reset SHALL be asynchronous and active-low.
REQ-002: Port `clk`, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003: Port `reset`, input, 1 bit: asynchronous active-low reset; 0 = in reset.
REQ-004: Port `Start`, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005: Port `MulOp`, input, 3 bits: operation code.
  - 3'b101 = MUL
  - 3'b110 = UMULL
  - 3'b111 = SMULL
  - all other values unsupported.
REQ-006: Port `Cancel`, input, 1 bit: synchronous abort (pipeline flush).
REQ-007: Port `SrcA`, input, 32 bits: multiplicand.
REQ-008: Port `SrcB`, input, 32 bits: multiplier.
REQ-009: Port `Busy`, output, 1 bit: high whenever the state is not IDLE; used by the main FSM to stall.
REQ-010: Port `Done`, output, 1 bit: one-cycle pulse marking a valid result.
REQ-011: Port `ResultLo`, output, 32 bits: low product word.
REQ-012: Port `ResultHi`, output, 32 bits: high product word.
REQ-013: Port `MulN`, output, 1 bit: negative flag of the result.
REQ-014: Port `MulZ`, output, 1 bit: zero flag of the result.

Function
REQ-015: The FSM SHALL have exactly four states: IDLE, CALC, FIX and DONE.
REQ-016: In IDLE, the block SHALL accept a request when Start=1 and MulOp is supported at a rising edge (edge E0):
  - latch MulOp;
  - latch operand magnitudes: absolute value of each operand for SMULL, raw value otherwise;
  - latch the result sign, which is SrcA[31] XOR SrcB[31] for SMULL and 0 otherwise;
  - clear the 64-bit accumulator and the 6-bit counter;
  - enter CALC.
REQ-017: In IDLE with Start=1 and an unsupported MulOp, the block SHALL stay in IDLE, and the outputs SHALL be unchanged.
REQ-018: In CALC, each edge SHALL process one bit of the multiplier as a radix-2 shift-add:
  - if the multiplier LSB = 1, add the shifted multiplicand (64-bit, no overflow possible) to the accumulator;
  - shift the multiplicand left by 1 and the multiplier right by 1;
  - increment the counter.
REQ-019: CALC SHALL last exactly 32 edges (E1..E32), and the block SHALL enter FIX at E32.
REQ-020: In FIX, at E33, the block SHALL form the final 64-bit value as the two's-complement negation of the accumulator if the latched sign = 1, otherwise the accumulator, and SHALL then:
  - load ResultLo with bits [31:0] of the final value;
  - load ResultHi with bits [63:32] for UMULL/SMULL, or 32'h0 for MUL;
  - enter DONE.
REQ-021: The flags SHALL be registered at E33:
  - MUL: MulN = ResultLo[31], MulZ = (ResultLo == 0);
  - UMULL/SMULL: MulN = ResultHi[31], MulZ = (the 64-bit result == 0).
REQ-022: Done SHALL be 1 only while in DONE, i.e. for the single cycle after E33; at E34 the block SHALL return to IDLE.
REQ-023: Total latency SHALL be Done high in the 34th cycle after the accepting edge E0; back-to-back operation SHALL allow a new Start to be accepted at E35 at the earliest.
REQ-024: Start SHALL be ignored while Busy=1, and a request SHALL NOT be queued.
REQ-025: ResultLo, ResultHi, MulN and MulZ SHALL hold their values until the next E33 and SHALL NOT change during CALC.
REQ-026: Cancel=1 at any edge SHALL force the state to IDLE and clear the counter, and Done SHALL NOT pulse for the aborted operation.
REQ-027: Result outputs SHALL retain their previous values on Cancel.
REQ-028: Cancel SHALL have priority over Start in the same cycle.
REQ-029: Operand inputs SHALL be sampled only at E0; changes on SrcA/SrcB after E0 SHALL NOT affect the result.
REQ-030: SMULL with an operand of 32'h80000000 SHALL handle the magnitude 2^31 correctly, using a 33-bit or unsigned magnitude path with no saturation.

Reset
REQ-031: While reset=0, the block SHALL asynchronously force the following, with the outputs fully deasserted within the same cycle:
  - state = IDLE;
  - Busy = 0, Done = 0;
  - ResultLo = 0, ResultHi = 0;
  - MulN = 0, MulZ = 0;
  - counter, accumulator and operand registers = 0.
REQ-032: An operation in progress when reset is asserted SHALL be discarded, and Done SHALL NOT pulse after reset is released.
REQ-033: The first Start SHALL be accepted at the first rising edge with reset=1.

Verification
REQ-034: The bench SHALL cover MUL: SrcA=7, SrcB=6, Start pulse -> Busy=1 from E0, Done=1 exactly 34 cycles later, ResultLo=42, ResultHi=0, MulN=0, MulZ=0.
REQ-035: The bench SHALL cover UMULL: SrcA=SrcB=32'hFFFFFFFF -> ResultHi=32'hFFFFFFFE, ResultLo=32'h00000001, MulN=1, MulZ=0.
REQ-036: The bench SHALL cover SMULL signed cases:
  - SrcA=32'hFFFFFFFF (-1), SrcB=1 -> ResultHi=ResultLo=32'hFFFFFFFF, MulN=1;
  - SrcA=SrcB=32'h80000000 -> ResultHi=32'h40000000, ResultLo=0, MulN=0.
REQ-037: The bench SHALL cover a zero product: MUL with SrcA=0, SrcB=32'h12345678 -> ResultLo=0, MulZ=1.
REQ-038: The bench SHALL cover control boundaries:
  - Start asserted again at cycle 10 of CALC -> ignored, single Done;
  - Cancel at cycle 5 of CALC -> Busy=0 next cycle, no Done, prior result outputs unchanged;
  - Start with MulOp=3'b000 -> Busy stays 0.
REQ-039: The bench SHALL cover reset mid-operation: reset=0 at cycle 20 of CALC -> Busy, Done, ResultLo, ResultHi, MulN and MulZ all 0 immediately; after release, no Done until a new Start, and the new MUL 3*5 gives ResultLo=15.

Source files
------------

// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Multi-cycle radix-2 shift-add multiplier for MUL, UMULL and SMULL.
// The multiplier accepts a request in IDLE (edge E0), performs 32
// shift-add steps in CALC (E1..E32), and applies the sign fix-up and
// loads the result in FIX (E33). It then pulses Done for one cycle in
// DONE and returns to IDLE at E34.
//
// SMULL multiplies unsigned magnitudes and negates the product at the
// end when the operand signs differ. The 32-bit unsigned magnitude
// represents 2^31 exactly, so 32'h80000000 needs no special case.
//
// Ports
//   clk      : clock; all state updates occur on the rising edge
//   reset    : asynchronous active-low reset
//   Start    : request to begin a multiply (sampled only in IDLE)
//   MulOp    : 3'b101 MUL, 3'b110 UMULL, 3'b111 SMULL; other values ignored
//   Cancel   : synchronous abort; returns the FSM to IDLE, results are kept
//   SrcA     : multiplicand (sampled only at the accepting edge)
//   SrcB     : multiplier   (sampled only at the accepting edge)
//   Busy     : high while the state is not IDLE
//   Done     : one-cycle pulse while the result is first valid
//   ResultLo : low product word
//   ResultHi : high product word (zero for MUL)
//   MulN     : negative flag of the result
//   MulZ     : zero flag of the result
// -----------------------------------------------------------------------------
module mul_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [2:0]        MulOp,
  input  logic              Cancel,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] ResultLo,
  output logic [DATA_W-1:0] ResultHi,
  output logic              MulN,
  output logic              MulZ
);

  localparam int          CNT_W    = 6;
  localparam int          PROD_W   = 2 * DATA_W;
  localparam logic [2:0]  OP_MUL   = 3'b101;
  localparam logic [2:0]  OP_UMULL = 3'b110;
  localparam logic [2:0]  OP_SMULL = 3'b111;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic              accept;
  logic [2:0]        op;
  logic              sign;
  logic [PROD_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [PROD_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic [PROD_W-1:0] fin;
  logic [DATA_W-1:0] res_lo_nxt;
  logic [DATA_W-1:0] res_hi_nxt;
  logic              n_nxt;
  logic              z_nxt;
  logic              is_smull;

  // Unsigned magnitude of a two's-complement value; the most negative
  // value maps onto 2^(DATA_W-1), which still fits the unsigned width.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = v;
    return v[DATA_W-1] ? (~u + 1'b1) : u;
  endfunction

  // Two's-complement negation of the full product when neg is set.
  function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] v,
                                                   input logic              neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic op_supported(input logic [2:0] o);
    return (o == OP_MUL) || (o == OP_UMULL) || (o == OP_SMULL);
  endfunction

  assign is_smull = (MulOp == OP_SMULL);

  // ---------------------------------------------------------------------------
  // Control: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; Cancel overrides everything, including a new Start.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (Start && op_supported(MulOp)) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == LAST_STEP) begin
          state_nxt = FIX;
        end
      end
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Cancel) begin
      state_nxt = IDLE;
      accept    = 1'b0;
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

  // ---------------------------------------------------------------------------
  // Result formation, consumed at the FIX edge
  // ---------------------------------------------------------------------------
  assign fin        = apply_sign(acc, sign);
  assign res_lo_nxt = fin[DATA_W-1:0];
  assign res_hi_nxt = (op == OP_MUL) ? '0 : fin[PROD_W-1:DATA_W];
  assign n_nxt      = (op == OP_MUL) ? fin[DATA_W-1] : fin[PROD_W-1];
  assign z_nxt      = (op == OP_MUL) ? (fin[DATA_W-1:0] == '0) : (fin == '0);

  // ---------------------------------------------------------------------------
  // Datapath: operand latch, shift-add steps, result load
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op       <= '0;
      sign     <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      ResultLo <= '0;
      ResultHi <= '0;
      MulN     <= 1'b0;
      MulZ     <= 1'b0;
    end else if (Cancel) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op     <= MulOp;
            mcand  <= {{DATA_W{1'b0}}, (is_smull ? magnitude($signed(SrcA)) : SrcA)};
            mplier <= is_smull ? magnitude($signed(SrcB)) : SrcB;
            sign   <= is_smull & (SrcA[DATA_W-1] ^ SrcB[DATA_W-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          ResultLo <= res_lo_nxt;
          ResultHi <= res_hi_nxt;
          MulN     <= n_nxt;
          MulZ     <= z_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
